pred_argmax: RTL and testbench

- Post-classifier stage directly downstream of the CNN top.
- Consumes the per-frame vector of NUM_CLASSES signed class scores (one vld pulse per frame).
- Finds the winning class index, its score, and the margin to the runner-up with a serial one-compare-per-cycle scan.
- Absorbs one frame of back-pressure-free input while busy, and flags overflow beyond that.

---
 rtl/pred_argmax.sv | 160 ++++++++++++++++
 tb/tb_pred_argmax.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pred_argmax.sv
// pred_argmax: serial argmax over one frame of signed class scores.
// Reports winning index, its score and margin to runner-up.
module pred_argmax #(
  parameter int NUM_CLASSES = 24,
  parameter int SCORE_W     = 10,
  parameter int IDX_W       = 5,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld_in,
  input  logic [SCORE_W-1:0] data_in [NUM_CLASSES],
  output logic               vld_out,
  output logic [IDX_W-1:0]   class_out,
  output logic [SCORE_W-1:0] score_out,
  output logic [SCORE_W-1:0] margin_out,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic               busy,
  output logic               overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic signed [SCORE_W-1:0] MIN_S =
    {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_CLASSES-1);

  state_t                     r_state;
  logic [SCORE_W-1:0]         r_buf  [NUM_CLASSES];
  logic [SCORE_W-1:0]         r_pend [NUM_CLASSES];
  logic                       r_pend_full;
  logic signed [SCORE_W-1:0]  r_best;
  logic signed [SCORE_W-1:0]  r_sec;
  logic [IDX_W-1:0]           r_idx;
  logic [IDX_W-1:0]           r_i;

  logic signed [SCORE_W-1:0]  w_e;
  logic signed [SCORE_W-1:0]  w_best_n;
  logic signed [SCORE_W-1:0]  w_sec_n;
  logic [IDX_W-1:0]           w_idx_n;
  logic signed [SCORE_W:0]    w_margin;
  logic                       w_last;
  logic                       w_consume;
  logic                       w_start;
  logic                       w_pend_ld;
  logic                       w_drop;
  logic [SCORE_W-1:0]         w_src [NUM_CLASSES];

  assign w_e    = $signed(r_buf[r_i]);
  assign w_last = (r_i == LAST_I);

  // A queued frame is consumed in the result cycle; a frame arriving
  // in that same cycle with nothing queued starts immediately.
  assign w_consume = (r_state == S_DONE) && r_pend_full;
  assign w_start   = ((r_state == S_IDLE) && vld_in) ||
                     ((r_state == S_DONE) && (r_pend_full || vld_in));
  assign w_pend_ld = vld_in &&
                     (((r_state == S_SCAN) && !r_pend_full) || w_consume);
  assign w_drop    = vld_in && (r_state == S_SCAN) && r_pend_full;

  assign busy = (r_state != S_IDLE) || r_pend_full;

  // Source of the next frame to scan: queued frame first, else input.
  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      w_src[k] = w_consume ? r_pend[k] : data_in[k];
    end
  end

  // One compare step; strict > keeps the lowest index on ties.
  always_comb begin
    w_best_n = r_best;
    w_sec_n  = r_sec;
    w_idx_n  = r_idx;
    if (w_e > r_best) begin
      w_sec_n  = r_best;
      w_best_n = w_e;
      w_idx_n  = r_i;
    end else if (w_e > r_sec) begin
      w_sec_n = w_e;
    end
  end

  // Margin is never negative, so SCORE_W+1 bits then truncation is exact.
  assign w_margin = {w_best_n[SCORE_W-1], w_best_n} -
                    {w_sec_n[SCORE_W-1], w_sec_n};

  // Scan FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_best     <= '0;
      r_sec      <= '0;
      r_idx      <= '0;
      r_i        <= '0;
      vld_out    <= 1'b0;
      class_out  <= '0;
      score_out  <= '0;
      margin_out <= '0;
      frame_cnt  <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) r_buf[k] <= '0;
    end else begin
      vld_out <= 1'b0;
      if (w_start) begin
        r_buf   <= w_src;
        r_best  <= $signed(w_src[0]);
        r_sec   <= MIN_S;
        r_idx   <= '0;
        r_i     <= IDX_W'(1);
        r_state <= S_SCAN;
      end
      unique case (r_state)
        S_IDLE: ;
        S_SCAN: begin
          r_best <= w_best_n;
          r_sec  <= w_sec_n;
          r_idx  <= w_idx_n;
          r_i    <= r_i + IDX_W'(1);
          if (w_last) begin
            class_out  <= w_idx_n;
            score_out  <= w_best_n;
            margin_out <= w_margin[SCORE_W-1:0];
            vld_out    <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          frame_cnt <= frame_cnt + CNT_W'(1);
          if (!w_start) begin
            r_i     <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // One-deep pending buffer and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_full <= 1'b0;
      overflow    <= 1'b0;
      for (int k = 0; k < NUM_CLASSES; k++) r_pend[k] <= '0;
    end else begin
      if (w_pend_ld) begin
        r_pend      <= data_in;
        r_pend_full <= 1'b1;
      end else if (w_consume) begin
        r_pend_full <= 1'b0;
      end
      if (w_drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pred_argmax.sv
// tb_pred_argmax: directed vector table plus back-to-back
// and mid-scan reset sequences for pred_argmax.
module tb_pred_argmax;

  localparam int NC = 24;
  localparam int SW = 10;
  localparam int IW = 5;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          vld_in;
  logic [SW-1:0] data_in [NC];
  logic          vld_out;
  logic [IW-1:0] class_out;
  logic [SW-1:0] score_out;
  logic [SW-1:0] margin_out;
  logic [CW-1:0] frame_cnt;
  logic          busy;
  logic          overflow;

  pred_argmax #(
    .NUM_CLASSES(NC),
    .SCORE_W    (SW),
    .IDX_W      (IW),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vld_in    (vld_in),
    .data_in   (data_in),
    .vld_out   (vld_out),
    .class_out (class_out),
    .score_out (score_out),
    .margin_out(margin_out),
    .frame_cnt (frame_cnt),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NC*SW-1:0] sc;
    logic [IW-1:0]    cls;
    logic [SW-1:0]    score;
    logic [SW-1:0]    margin;
  } vec_t;

  vec_t vecs [6];
  int   n_run;
  int   n_fail;
  int   exp_cnt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [NC*SW-1:0] sc);
    for (int i = 0; i < NC; i++) data_in[i] = sc[i*SW +: SW];
  endtask

  function automatic logic [NC*SW-1:0] pack(input logic [SW-1:0] t [NC]);
    logic [NC*SW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*SW +: SW] = t[i];
    return r;
  endfunction

  // One frame; expect a single pulse 23 cycles after the sampling edge.
  task automatic run_frame(input vec_t v, input string tag);
    int lat;
    int np;
    logic [IW-1:0] c;
    logic [SW-1:0] s;
    logic [SW-1:0] m;
    lat = 0; np = 0; c = '0; s = '0; m = '0;
    @(negedge clk);
    drive(v.sc);
    vld_in = 1'b1;
    @(posedge clk);
    #1 vld_in = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (vld_out) begin
        np++;
        if (lat == 0) begin
          lat = k; c = class_out; s = score_out; m = margin_out;
        end
      end
    end
    exp_cnt++;
    chk({tag, " latency"}, lat, 23);
    chk({tag, " pulses"}, np, 1);
    chk({tag, " class"}, c, v.cls);
    chk({tag, " score"}, s, v.score);
    chk({tag, " margin"}, m, v.margin);
    chk({tag, " held class"}, class_out, v.cls);
    chk({tag, " frame_cnt"}, frame_cnt, exp_cnt);
    chk({tag, " busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [SW-1:0] t [NC];
    int p1, p2, np;
    logic [IW-1:0] c1, c2;
    logic [SW-1:0] m1, s2;

    n_run = 0; n_fail = 0; exp_cnt = 0;
    vld_in = 1'b0;
    for (int i = 0; i < NC; i++) data_in[i] = '0;

    t = '{10'h2f5, 10'h32f, 10'h2df, 10'h357, 10'h336, 10'h007,
          10'h3ef, 10'h3ae, 10'h3af, 10'h3b0, 10'h3a1, 10'h39a,
          10'h3a5, 10'h3a9, 10'h3a9, 10'h387, 10'h358, 10'h34c,
          10'h34a, 10'h31e, 10'h364, 10'h3a9, 10'h3a5, 10'h36c};
    vecs[0] = '{pack(t), 5'd5, 10'h007, 10'h018};
    for (int i = 0; i < NC; i++) t[i] = 10'h200;
    vecs[1] = '{pack(t), 5'd0, 10'h200, 10'h000};
    for (int i = 0; i < NC; i++) t[i] = 10'h000;
    t[3] = 10'h050; t[17] = 10'h050;
    vecs[2] = '{pack(t), 5'd3, 10'h050, 10'h000};
    for (int i = 0; i < NC; i++) t[i] = 10'h200;
    t[23] = 10'h1ff;
    vecs[3] = '{pack(t), 5'd23, 10'h1ff, 10'h3ff};
    for (int i = 0; i < NC; i++) t[i] = SW'(i * 10);
    vecs[4] = '{pack(t), 5'd23, 10'h0e6, 10'h00a};
    for (int i = 0; i < NC; i++) t[i] = 10'h000;
    t[0] = 10'h1ff; t[23] = 10'h1fe;
    vecs[5] = '{pack(t), 5'd0, 10'h1ff, 10'h001};

    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset vld_out", vld_out, 1'b0);
    chk("reset class", class_out, 0);
    chk("reset score", score_out, 0);
    chk("reset margin", margin_out, 0);
    chk("reset frame_cnt", frame_cnt, 0);
    chk("reset busy", busy, 1'b0);
    chk("reset overflow", overflow, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v], $sformatf("vec%0d", v));
    end
    chk("table overflow", overflow, 1'b0);

    // Three frames on consecutive cycles: two results, third dropped.
    p1 = 0; p2 = 0; np = 0; c1 = '0; c2 = '0; m1 = '0; s2 = '0;
    @(negedge clk);
    drive(vecs[0].sc); vld_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(vecs[2].sc);
    @(posedge clk);
    @(negedge clk);
    drive(vecs[3].sc);
    @(posedge clk);
    @(negedge clk);
    vld_in = 1'b0;
    chk("b2b busy", busy, 1'b1);
    for (int k = 3; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (vld_out) begin
        np++;
        if (np == 1) begin
          p1 = k; c1 = class_out; m1 = margin_out;
        end else if (np == 2) begin
          p2 = k; c2 = class_out; s2 = score_out;
        end
      end
    end
    exp_cnt += 2;
    chk("b2b first pulse", p1, 23);
    chk("b2b second pulse", p2, 47);
    chk("b2b pulses", np, 2);
    chk("b2b class1", c1, 5);
    chk("b2b margin1", m1, 10'h018);
    chk("b2b class2", c2, 3);
    chk("b2b score2", s2, 10'h050);
    chk("b2b overflow", overflow, 1'b1);
    chk("b2b frame_cnt", frame_cnt, exp_cnt);
    chk("b2b busy end", busy, 1'b0);

    // Reset ten cycles into a scan.
    @(negedge clk);
    drive(vecs[3].sc); vld_in = 1'b1;
    @(posedge clk);
    #1 vld_in = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst vld_out", vld_out, 1'b0);
    chk("midrst class", class_out, 0);
    chk("midrst score", score_out, 0);
    chk("midrst margin", margin_out, 0);
    chk("midrst frame_cnt", frame_cnt, 0);
    chk("midrst overflow", overflow, 1'b0);
    chk("midrst busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    np = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (vld_out) np++;
    end
    chk("midrst no pulse", np, 0);
    exp_cnt = 0;
    run_frame(vecs[1], "post-reset");
    chk("post-reset overflow", overflow, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
